// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU sequencer types, opcode/memory constants and instruction classification
package cpu_pkg;

   typedef enum logic [2:0] {
      S_FETCH,
      S_LOAD_IR,
      S_ISSUE,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_HALT
   } seq_state_t;

   localparam logic [2:0] OP_MOV  = 3'b110;
   localparam logic [2:0] OP_ALU  = 3'b101;
   localparam logic [2:0] OP_HALT = 3'b111;

   localparam logic [1:0] MNONE  = 2'b00;
   localparam logic [1:0] MREAD  = 2'b01;
   localparam logic [1:0] MWRITE = 2'b10;

   localparam int OPCODE_MSB = 15;
   localparam int OPCODE_LSB = 13;
   localparam int OPF_MSB    = 12;
   localparam int OPF_LSB    = 11;

   function automatic logic [2:0] instr_opcode(input logic [15:0] instr);
      return instr[OPCODE_MSB:OPCODE_LSB];
   endfunction

   function automatic logic [1:0] instr_op(input logic [15:0] instr);
      return instr[OPF_MSB:OPF_LSB];
   endfunction

   function automatic logic is_halt(input logic [15:0] instr);
      return instr_opcode(instr) == OP_HALT;
   endfunction

   // Only encodings the datapath FSM actually executes; anything else would never drop w.
   function automatic logic is_legal(input logic [15:0] instr);
      logic [2:0] w_opc;
      logic [1:0] w_fld;
      w_opc = instr_opcode(instr);
      w_fld = instr_op(instr);
      return (w_opc == OP_ALU) || ((w_opc == OP_MOV) && ((w_fld == 2'b10) || (w_fld == 2'b00)));
   endfunction

endpackage

// File: rtl/instr_fetch_sequencer.sv
// rtl/instr_fetch_sequencer.sv - instruction fetch/issue sequencer with shared memory port arbitration
module instr_fetch_sequencer
   import cpu_pkg::*;
#(
   parameter int ADDR_W   = 9,
   parameter int DATA_W   = 16,
   parameter int RESET_PC = 0
)(
   input  logic              clk,
   input  logic              reset,
   output logic [1:0]        mem_cmd,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] ir,
   output logic [2:0]        opcode,
   output logic [1:0]        op,
   output logic              s,
   input  logic              w,
   input  logic              dp_req,
   input  logic              dp_we,
   input  logic [ADDR_W-1:0] dp_addr,
   input  logic [DATA_W-1:0] dp_wdata,
   output logic              dp_gnt,
   output logic              dp_rvalid,
   output logic [DATA_W-1:0] dp_rdata,
   output logic [ADDR_W-1:0] pc,
   output logic              halted
);

   seq_state_t        r_state;
   seq_state_t        w_next;
   logic [ADDR_W-1:0] r_pc;
   logic [DATA_W-1:0] r_ir;
   logic              r_halted;
   logic              r_dp_rvalid;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:     w_next = S_LOAD_IR;
         S_LOAD_IR:   w_next = S_ISSUE;
         S_ISSUE: begin
            if (is_halt(r_ir[15:0]))       w_next = S_HALT;
            else if (is_legal(r_ir[15:0])) w_next = S_WAIT_BUSY;
            else                           w_next = S_FETCH;
         end
         S_WAIT_BUSY: if (!w) w_next = S_WAIT_DONE;
         S_WAIT_DONE: if (w)  w_next = S_FETCH;
         S_HALT:      w_next = S_HALT;
         default:     w_next = S_FETCH;
      endcase
   end

   // The datapath only sees the port while an instruction is in flight.
   always_comb begin
      mem_cmd   = MNONE;
      mem_addr  = r_pc;
      mem_wdata = '0;
      s         = 1'b0;
      dp_gnt    = 1'b0;
      case (r_state)
         S_FETCH: mem_cmd = MREAD;
         S_ISSUE: s = is_legal(r_ir[15:0]);
         S_WAIT_BUSY, S_WAIT_DONE: begin
            dp_gnt = dp_req;
            if (dp_req) begin
               mem_cmd   = dp_we ? MWRITE : MREAD;
               mem_addr  = dp_addr;
               mem_wdata = dp_wdata;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc        <= ADDR_W'(RESET_PC);
         r_ir        <= '0;
         r_halted    <= 1'b0;
         r_dp_rvalid <= 1'b0;
      end else begin
         r_dp_rvalid <= dp_gnt && !dp_we;
         if (r_state == S_LOAD_IR) begin
            r_ir <= mem_rdata;
            r_pc <= r_pc + ADDR_W'(1);
         end
         if ((r_state == S_ISSUE) && is_halt(r_ir[15:0])) r_halted <= 1'b1;
      end
   end

   assign ir        = r_ir;
   assign opcode    = instr_opcode(r_ir[15:0]);
   assign op        = instr_op(r_ir[15:0]);
   assign pc        = r_pc;
   assign halted    = r_halted;
   assign dp_rvalid = r_dp_rvalid;
   assign dp_rdata  = mem_rdata;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// tb/tb_instr_fetch_sequencer.sv - table-driven self-checking bench for instr_fetch_sequencer
module tb_instr_fetch_sequencer;
   import cpu_pkg::*;

   localparam int CN = 0;
   localparam int CR = 1;
   localparam int CW = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  mem_cmd;
   logic [8:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata = 16'h0;
   logic [15:0] ir;
   logic [2:0]  opcode;
   logic [1:0]  op;
   logic        s;
   logic        w;
   logic        dp_req;
   logic        dp_we;
   logic [8:0]  dp_addr;
   logic [15:0] dp_wdata;
   logic        dp_gnt;
   logic        dp_rvalid;
   logic [15:0] dp_rdata;
   logic [8:0]  pc;
   logic        halted;

   logic [1:0]  mem_cmd_b;
   logic [8:0]  mem_addr_b;
   logic [15:0] mem_wdata_b;
   logic [15:0] mem_rdata_b = 16'h0;
   logic [15:0] ir_b;
   logic [2:0]  opcode_b;
   logic [1:0]  op_b;
   logic        s_b;
   logic        dp_gnt_b;
   logic        dp_rvalid_b;
   logic [15:0] dp_rdata_b;
   logic [8:0]  pc_b;
   logic        halted_b;

   logic [15:0] ram [0:511];
   logic [15:0] sb [$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_writes = 0;

   typedef struct {
      logic        w;
      logic        req;
      logic        we;
      logic [8:0]  addr;
      logic [15:0] wd;
      logic [1:0]  e_cmd;
      logic [8:0]  e_addr;
      logic [15:0] e_wdata;
      logic        e_s;
      logic        e_gnt;
      logic        e_rv;
      logic [8:0]  e_pc;
      logic [15:0] e_ir;
      logic        e_halt;
   } vec_t;

   vec_t tbl [$];
   int   seg [5];

   instr_fetch_sequencer #(.ADDR_W(9), .DATA_W(16), .RESET_PC(0)) dut (
      .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .ir(ir), .opcode(opcode),
      .op(op), .s(s), .w(w), .dp_req(dp_req), .dp_we(dp_we), .dp_addr(dp_addr),
      .dp_wdata(dp_wdata), .dp_gnt(dp_gnt), .dp_rvalid(dp_rvalid),
      .dp_rdata(dp_rdata), .pc(pc), .halted(halted)
   );

   instr_fetch_sequencer #(.ADDR_W(9), .DATA_W(16), .RESET_PC(9'h1FF)) dut_wrap (
      .clk(clk), .reset(reset), .mem_cmd(mem_cmd_b), .mem_addr(mem_addr_b),
      .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .ir(ir_b), .opcode(opcode_b),
      .op(op_b), .s(s_b), .w(1'b1), .dp_req(1'b0), .dp_we(1'b0), .dp_addr(9'h000),
      .dp_wdata(16'h0000), .dp_gnt(dp_gnt_b), .dp_rvalid(dp_rvalid_b),
      .dp_rdata(dp_rdata_b), .pc(pc_b), .halted(halted_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_cmd == MREAD) mem_rdata <= ram[mem_addr];
      else if (mem_cmd == MWRITE) ram[mem_addr] = mem_wdata;
   end

   always @(posedge clk)
      mem_rdata_b <= (mem_cmd_b == MREAD && mem_addr_b == 9'h1FF) ? 16'hD001 : 16'h0000;

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1);
   end

   function automatic vec_t mk(input int w_, req_, we_, a_, d_, c_, ea_, ed_,
                               es_, eg_, erv_, epc_, eir_, eh_);
      vec_t r;
      r.w = 1'(w_);        r.req = 1'(req_);    r.we = 1'(we_);
      r.addr = 9'(a_);     r.wd = 16'(d_);      r.e_cmd = 2'(c_);
      r.e_addr = 9'(ea_);  r.e_wdata = 16'(ed_);
      r.e_s = 1'(es_);     r.e_gnt = 1'(eg_);   r.e_rv = 1'(erv_);
      r.e_pc = 9'(epc_);   r.e_ir = 16'(eir_);  r.e_halt = 1'(eh_);
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic apply_reset();
      reset = 1'b1; w = 1'b1; dp_req = 1'b0; dp_we = 1'b0; dp_addr = '0; dp_wdata = '0;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic run_rows(input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         vec_t        v;
         logic [63:0] a;
         logic [63:0] e;
         v = tbl[i];
         w = v.w; dp_req = v.req; dp_we = v.we; dp_addr = v.addr; dp_wdata = v.wd;
         if (v.req && !v.we && v.e_gnt) sb.push_back(ram[v.addr]);
         @(negedge clk);
         a = {3'b0, mem_cmd, (v.e_cmd == MNONE) ? 9'h0 : mem_addr, mem_wdata, s, dp_gnt,
              dp_rvalid, pc, ir, halted, opcode, op};
         e = {3'b0, v.e_cmd, v.e_addr, v.e_wdata, v.e_s, v.e_gnt, v.e_rv, v.e_pc, v.e_ir,
              v.e_halt, v.e_ir[15:13], v.e_ir[12:11]};
         check($sformatf("row%0d", i), a, e);
         if (mem_cmd == MWRITE) n_writes++;
         if (dp_rvalid) begin
            if (sb.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL sb_rdata act=unexpected_rvalid(%h) exp=no_rvalid", dp_rdata);
            end else begin
               check("sb_rdata", 64'(dp_rdata), 64'(sb.pop_front()));
            end
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int base;
      for (int i = 0; i < 512; i++) ram[i] = 16'h0;
      w = 1'b1; dp_req = 1'b0; dp_we = 1'b0; dp_addr = '0; dp_wdata = '0;

      // w, req, we, addr, wd | cmd, addr, wdata, s, gnt, rv, pc, ir, halted
      seg[0] = tbl.size();
      tbl.push_back(mk(1,0,0,0,0, CR,0,0, 0,0,0, 0,'h0000,0));
      tbl.push_back(mk(1,0,0,0,0, CN,0,0, 0,0,0, 0,'h0000,0));
      tbl.push_back(mk(1,0,0,0,0, CN,0,0, 1,0,0, 1,'hD007,0));
      tbl.push_back(mk(1,0,0,0,0, CN,0,0, 0,0,0, 1,'hD007,0));
      tbl.push_back(mk(0,0,0,0,0, CN,0,0, 0,0,0, 1,'hD007,0));
      tbl.push_back(mk(1,0,0,0,0, CN,0,0, 0,0,0, 1,'hD007,0));
      tbl.push_back(mk(1,0,0,0,0, CR,1,0, 0,0,0, 1,'hD007,0));
      tbl.push_back(mk(1,0,0,0,0, CN,0,0, 0,0,0, 1,'hD007,0));
      tbl.push_back(mk(1,0,0,0,0, CN,0,0, 0,0,0, 2,'hE000,0));
      tbl.push_back(mk(1,0,0,0,0, CN,0,0, 0,0,0, 2,'hE000,1));
      seg[1] = tbl.size();
      tbl.push_back(mk(1,0,0,0,0, CR,0,0, 0,0,0, 0,'h0000,0));
      tbl.push_back(mk(1,0,0,0,0, CN,0,0, 0,0,0, 0,'h0000,0));
      tbl.push_back(mk(1,0,0,0,0, CN,0,0, 0,0,0, 1,'h0000,0));
      tbl.push_back(mk(1,0,0,0,0, CR,1,0, 0,0,0, 1,'h0000,0));
      tbl.push_back(mk(1,0,0,0,0, CN,0,0, 0,0,0, 1,'h0000,0));
      tbl.push_back(mk(1,0,0,0,0, CN,0,0, 0,0,0, 2,'hE000,0));
      tbl.push_back(mk(1,0,0,0,0, CN,0,0, 0,0,0, 2,'hE000,1));
      seg[2] = tbl.size();
      tbl.push_back(mk(1,0,0,0,0,          CR,0,0,          0,0,0, 0,'h0000,0));
      tbl.push_back(mk(1,0,0,0,0,          CN,0,0,          0,0,0, 0,'h0000,0));
      tbl.push_back(mk(1,0,0,0,0,          CN,0,0,          1,0,0, 1,'hA0A1,0));
      tbl.push_back(mk(1,1,0,'h1F0,0,      CR,'h1F0,0,      0,1,0, 1,'hA0A1,0));
      tbl.push_back(mk(0,0,0,0,0,          CN,0,0,          0,0,1, 1,'hA0A1,0));
      tbl.push_back(mk(0,1,1,'h1F1,'h1234, CW,'h1F1,'h1234, 0,1,0, 1,'hA0A1,0));
      tbl.push_back(mk(0,0,0,0,0,          CN,0,0,          0,0,0, 1,'hA0A1,0));
      tbl.push_back(mk(1,1,0,'h1F0,0,      CR,'h1F0,0,      0,1,0, 1,'hA0A1,0));
      tbl.push_back(mk(1,0,0,0,0,          CR,1,0,          0,0,1, 1,'hA0A1,0));
      tbl.push_back(mk(1,0,0,0,0,          CN,0,0,          0,0,0, 1,'hA0A1,0));
      seg[3] = tbl.size();
      tbl.push_back(mk(1,1,1,'h100,'hBEEF, CR,0,0,          0,0,0, 0,'h0000,0));
      tbl.push_back(mk(1,1,1,'h100,'hBEEF, CN,0,0,          0,0,0, 0,'h0000,0));
      tbl.push_back(mk(1,1,1,'h100,'hBEEF, CN,0,0,          1,0,0, 1,'hD007,0));
      tbl.push_back(mk(0,1,1,'h100,'hBEEF, CW,'h100,'hBEEF, 0,1,0, 1,'hD007,0));
      tbl.push_back(mk(0,0,0,0,0,          CN,0,0,          0,0,0, 1,'hD007,0));
      seg[4] = tbl.size();

      // PC wrap on the RESET_PC=0x1FF instance
      apply_reset();
      @(negedge clk);
      check("wrap_fetch", 64'({mem_cmd_b, mem_addr_b, pc_b, ir_b}), 64'({MREAD, 9'h1FF, 9'h1FF, 16'h0000}));
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      check("wrap_issue", 64'({pc_b, ir_b, s_b}), 64'({9'h000, 16'hD001, 1'b1}));

      // MOV then HALT
      ram[0] = 16'hD007; ram[1] = 16'hE000;
      apply_reset();
      run_rows(seg[0], seg[1]);
      dp_req = 1'b1; dp_we = 1'b1; dp_addr = 9'h055; dp_wdata = 16'hFFFF; w = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         check($sformatf("halt_hold%0d", k), 64'({mem_cmd, halted, s, dp_gnt, pc}),
               64'({MNONE, 1'b1, 1'b0, 1'b0, 9'd2}));
         @(posedge clk); #1;
      end

      // illegal encoding acts as NOP
      ram[0] = 16'h0000;
      apply_reset();
      run_rows(seg[1], seg[2]);

      // ALU with datapath read, write and read-at-completion
      ram[0] = 16'hA0A1; ram[9'h1F0] = 16'h5A5A; ram[9'h1F1] = 16'h0000;
      apply_reset();
      run_rows(seg[2], seg[3]);
      check("dp_write_mem", 64'(ram[9'h1F1]), 64'(16'h1234));

      // write request held through fetch phases
      ram[0] = 16'hD007; ram[9'h100] = 16'h0000;
      apply_reset();
      base = n_writes;
      run_rows(seg[3], seg[4]);
      check("write_once", 64'(n_writes - base), 64'(1));
      check("write_mem", 64'(ram[9'h100]), 64'(16'hBEEF));

      // reset while in WAIT_DONE
      dp_req = 1'b1; dp_we = 1'b1; dp_addr = 9'h100; w = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("reset_wait_done", 64'({mem_cmd, mem_addr, pc, ir, s, halted, dp_gnt, dp_rvalid}),
            64'({MREAD, 9'h000, 9'h000, 16'h0000, 4'b0000}));

      check("sb_drain", 64'(sb.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
